spi_shift: RTL and testbench

SPI_SHIFT -- requirements
Module: spi_shift

---
 rtl/spi_pkg.sv | 48 ++++
 rtl/spi_edge_det.sv | 39 +++
 rtl/spi_shift.sv | 185 ++++++++++++++++++
 tb/tb_spi_shift.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine.
// Holds the w_r_mode encodings, the FSM state encoding, and helpers that
// derive the transaction length and width validity from the latched request.
package spi_pkg;

    localparam logic [1:0] MODE_RD   = 2'b00;  // read only
    localparam logic [1:0] MODE_WR   = 2'b01;  // write only
    localparam logic [1:0] MODE_WRRD = 2'b10;  // write then read (2'b11 aliases this)

    localparam int unsigned SR_W = 32;         // internal shift-register width

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A single width field is usable when it lies in 1..32
    function automatic logic width_ok(input logic [5:0] w);
        return (w != 6'd0) && (w <= 6'd32);
    endfunction

    // Every width that the selected mode actually uses must be usable
    function automatic logic widths_valid(input logic [1:0] mode,
                                          input logic [5:0] wr_w,
                                          input logic [5:0] rd_w);
        logic ok;
        case (mode)
            MODE_RD: ok = width_ok(rd_w);
            MODE_WR: ok = width_ok(wr_w);
            default: ok = width_ok(wr_w) && width_ok(rd_w);
        endcase
        return ok;
    endfunction

    // Number of SCK sample edges the transaction is expected to carry
    function automatic logic [6:0] total_bits(input logic [1:0] mode,
                                              input logic [5:0] wr_w,
                                              input logic [5:0] rd_w);
        logic [6:0] tot;
        case (mode)
            MODE_RD: tot = {1'b0, rd_w};
            MODE_WR: tot = {1'b0, wr_w};
            default: tot = {1'b0, wr_w} + {1'b0, rd_w};
        endcase
        return tot;
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Edge detector for the CS/SCK timing block outputs.
// Ports: clk, rst_n (async active-low), cpol (SCK idle level), cs, sck in;
//        cs_fall, cs_rise, sck_lead (away from cpol), sck_trail (back to cpol)
//        out, all combinational against the one-cycle-delayed copies.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic cpol,
    input  logic cs,
    input  logic sck,
    output logic cs_fall,
    output logic cs_rise,
    output logic sck_lead,
    output logic sck_trail
);

    logic cs_q;   // cs delayed by one clk
    logic sck_q;  // sck delayed by one clk

    // One-cycle delay of cs/sck; reset to their idle levels so no edge fires out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= 1'b1;
            sck_q <= cpol;
        end else begin
            cs_q  <= cs;
            sck_q <= sck;
        end
    end

    // Edge classification relative to the configured SCK idle level
    always_comb begin
        cs_fall   = !cs && cs_q;
        cs_rise   = cs && !cs_q;
        sck_lead  = (sck != sck_q) && (sck != cpol);
        sck_trail = (sck != sck_q) && (sck == cpol);
    end

endmodule

// File: rtl/spi_shift.sv
// SPI master shift engine. Serialises wr_data on mosi and collects miso into
// rd_data, following CS/SCK produced by a separate timing block.
// Ports: clk, rst_n (async active-low), en, cpol, cpha, w_r_mode, wr_width,
//        rd_width, wr_data, cs, sck, miso in; mosi, rd_data, rd_valid (pulse),
//        done (pulse), err (qualifies done) out. All outputs are registered.
module spi_shift #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [1:0]        w_r_mode,
    input  logic [5:0]        wr_width,
    input  logic [5:0]        rd_width,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cs,
    input  logic              sck,
    input  logic              miso,
    output logic              mosi,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err
);
    import spi_pkg::*;

    logic cs_fall, cs_rise, sck_lead, sck_trail;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [5:0]        wr_w_q, wr_w_d;
    logic [6:0]        tot_q, tot_d;
    logic              ok_q, ok_d;        // latched widths were valid
    logic              first_q, first_d;  // next leading edge is the first (cpha=1 launch)
    logic [6:0]        bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]   tx_sr_q, tx_sr_d;
    logic [SR_W-1:0]   rx_sr_q, rx_sr_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [SR_W-1:0]   wr_ext_s;
    logic              sample_s, shift_s, rd_phase_s;

    spi_edge_det u_edge_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpol      (cpol),
        .cs        (cs),
        .sck       (sck),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sck_lead  (sck_lead),
        .sck_trail (sck_trail)
    );

    // Next-state, shift-register and output computation
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_w_d     = wr_w_q;
        tot_d      = tot_q;
        ok_d       = ok_q;
        first_d    = first_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        wr_ext_s             = {SR_W{1'b0}};
        wr_ext_s[DATA_W-1:0] = wr_data;

        // cpha selects which SCK edge samples and which one moves the next bit out
        sample_s   = cpha ? sck_trail : sck_lead;
        shift_s    = cpha ? (sck_lead && !first_q) : sck_trail;
        // Bit index bit_cnt_q is a read bit in read-only mode or past the write field
        rd_phase_s = (mode_q == MODE_RD) ||
                     ((mode_q != MODE_WR) && (bit_cnt_q >= {1'b0, wr_w_q}));

        if (!en) begin
            state_d   = IDLE;
            bit_cnt_d = 7'd0;
            tx_sr_d   = {SR_W{1'b0}};
            rx_sr_d   = {SR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = SHIFT;
                        mode_d    = w_r_mode;
                        wr_w_d    = wr_width;
                        tot_d     = total_bits(w_r_mode, wr_width, rd_width);
                        ok_d      = widths_valid(w_r_mode, wr_width, rd_width);
                        first_d   = 1'b1;
                        bit_cnt_d = 7'd0;
                        // MSB-align the right-aligned word so bit 31 is always the next bit out
                        tx_sr_d   = wr_ext_s << (6'd32 - wr_width);
                        rx_sr_d   = {SR_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        if (ok_q && (bit_cnt_q == tot_q)) begin
                            err_d      = 1'b0;
                            rd_valid_d = (mode_q != MODE_WR);
                            rd_data_d  = (mode_q != MODE_WR) ? rx_sr_q[DATA_W-1:0] : rd_data_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        first_d = (cpha && sck_lead) ? 1'b0 : first_q;
                        tx_sr_d = shift_s ? {tx_sr_q[SR_W-2:0], 1'b0} : tx_sr_q;
                        // Saturate at tot: extra sample edges leave count and rx untouched
                        if (sample_s && ok_q && (bit_cnt_q < tot_q)) begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                            rx_sr_d   = rd_phase_s ? {rx_sr_q[SR_W-2:0], miso} : rx_sr_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // mosi reflects the upcoming state so the first bit appears right after cs_fall
        mosi_d = ((state_d == SHIFT) && ok_d && (mode_d != MODE_RD) &&
                  (bit_cnt_d < {1'b0, wr_w_d})) ? tx_sr_d[SR_W-1] : 1'b0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            wr_w_q     <= 6'd0;
            tot_q      <= 7'd0;
            ok_q       <= 1'b0;
            first_q    <= 1'b0;
            bit_cnt_q  <= 7'd0;
            tx_sr_q    <= {SR_W{1'b0}};
            rx_sr_q    <= {SR_W{1'b0}};
            mosi_q     <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_w_q     <= wr_w_d;
            tot_q      <= tot_d;
            ok_q       <= ok_d;
            first_q    <= first_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            mosi_q     <= mosi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mosi     = mosi_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_shift.sv
// Self-checking bench for spi_shift: acts as CS/SCK timing block and SPI slave,
// predicts mosi bit streams, done/err/rd_valid and rd_data from the transfer rules.
module tb_spi_shift;

    localparam int HALF = 2;  // clk cycles per SCK half period

    logic        clk = 1'b0;
    logic        rst_n, en, cpol, cpha, cs, sck, miso;
    logic [1:0]  w_r_mode;
    logic [5:0]  wr_width, rd_width;
    logic [31:0] wr_data;
    logic        mosi, rd_valid, done, err;
    logic [31:0] rd_data;

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test = "reset";

    int    done_cnt = 0;
    int    rdv_cnt  = 0;
    logic  last_err = 1'b0;
    logic  last_rdv = 1'b0;
    logic [31:0] model_rd = 32'd0;

    spi_shift #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cpol(cpol), .cpha(cpha),
        .w_r_mode(w_r_mode), .wr_width(wr_width), .rd_width(rd_width),
        .wr_data(wr_data), .cs(cs), .sck(sck), .miso(miso),
        .mosi(mosi), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts done and rd_valid and records what accompanied done
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            last_err = err;
            last_rdv = rd_valid;
        end
        if (rd_valid) rdv_cnt = rdv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, got, exp);
        end
    endtask

    function automatic bit model_valid(input logic [1:0] m, input int ww, input int rw);
        bit wv, rv;
        wv = (ww >= 1) && (ww <= 32);
        rv = (rw >= 1) && (rw <= 32);
        if (m == 2'b00) return rv;
        else if (m == 2'b01) return wv;
        else return wv && rv;
    endfunction

    function automatic int model_tot(input logic [1:0] m, input int ww, input int rw);
        if (m == 2'b00) return rw;
        else if (m == 2'b01) return ww;
        else return ww + rw;
    endfunction

    // One transaction with n SCK periods; drop_at >= 0 pulls en low before that bit
    task automatic run_xfer(input logic [1:0] m, input bit pol, input bit pha,
                            input logic [5:0] ww6, input logic [5:0] rw6,
                            input logic [31:0] wd, input logic [31:0] sd,
                            input int n, input int drop_at);
        int ww, rw, j, d0, r0;
        bit valid, wmode, alive, exp_done, complete, exp_rdv;
        logic [63:0] got_w, exp_w, mask;
        ww = ww6; rw = rw6;
        valid    = model_valid(m, ww, rw);
        wmode    = (m != 2'b00);
        exp_done = (drop_at < 0);
        complete = exp_done && valid && (n >= model_tot(m, ww, rw));
        exp_rdv  = complete && (m != 2'b01);

        @(negedge clk);
        cpol = pol; cpha = pha; sck = pol;
        w_r_mode = m; wr_width = ww6; rd_width = rw6; wr_data = wd;
        repeat (3) @(negedge clk);
        d0 = done_cnt; r0 = rdv_cnt;
        cs = 1'b0;
        @(negedge clk);
        // Request inputs must be ignored once the transaction has started
        w_r_mode = 2'($urandom); wr_width = 6'($urandom);
        rd_width = 6'($urandom); wr_data = $urandom;
        @(negedge clk);

        alive = 1'b1; got_w = 64'd0; exp_w = 64'd0;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                en = 1'b0;
                repeat (2) @(negedge clk);
                en = 1'b1;
                alive = 1'b0;
            end
            for (int ph = 0; ph < 2; ph++) begin
                if ((ph == 0) == !pha) begin
                    // Slave side of a sample edge: read mosi, present miso
                    if (i < 64) begin
                        got_w[63-i] = mosi;
                        if (alive && valid && wmode && (i < ww)) exp_w[63-i] = wd[ww-1-i];
                        else exp_w[63-i] = 1'b0;
                    end
                    if (m == 2'b00) j = i;
                    else if (m != 2'b01 && i >= ww) j = i - ww;
                    else j = -1;
                    if (j >= 0 && j < rw && rw <= 32) miso = sd[rw-1-j];
                    else miso = 1'($urandom);
                end
                sck = (ph == 0) ? !pol : pol;
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        cs = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        repeat (3) @(negedge clk);
        #1;

        if (exp_rdv) begin
            mask = (64'd1 << rw) - 64'd1;
            model_rd = sd & mask[31:0];
        end
        chk("mosi", got_w, exp_w);
        chk("done_cnt", 64'(done_cnt - d0), 64'(exp_done));
        if (exp_done) chk("err", 64'(last_err), 64'(!complete));
        chk("rdv_cnt", 64'(rdv_cnt - r0), 64'(exp_rdv));
        if (exp_done) chk("rdv_with_done", 64'(last_rdv), 64'(exp_rdv));
        chk("rd_data", 64'(rd_data), 64'(model_rd));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cpol = 1'b0; cpha = 1'b0; cs = 1'b1; sck = 1'b0;
        miso = 1'b0; w_r_mode = 2'b00; wr_width = 6'd8; rd_width = 6'd8; wr_data = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        cur_test = "wr_a5";
        run_xfer(2'b01, 1'b0, 1'b0, 6'd8, 6'd8, 32'h0000_00A5, 32'd0, 8, -1);
        cur_test = "rd_abc";
        run_xfer(2'b00, 1'b1, 1'b1, 6'd8, 6'd12, 32'd0, 32'h0000_0ABC, 12, -1);
        cur_test = "wrrd_9f";
        run_xfer(2'b10, 1'b0, 1'b0, 6'd8, 6'd24, 32'h0000_009F, 32'h00EF_4018, 32, -1);
        for (int pc = 0; pc < 4; pc++) begin
            cur_test = $sformatf("rd32_pc%0d", pc);
            run_xfer(2'b00, pc[1], pc[0], 6'd8, 6'd32, 32'd0, 32'hFFFF_FFFF, 32, -1);
        end
        cur_test = "wr_width0";
        run_xfer(2'b01, 1'b0, 1'b0, 6'd0, 6'd8, 32'h0000_00FF, 32'd0, 8, -1);
        cur_test = "abort5of16";
        run_xfer(2'b00, 1'b0, 1'b0, 6'd8, 6'd16, 32'd0, 32'h0000_1234, 5, -1);
        cur_test = "en_drop";
        run_xfer(2'b10, 1'b0, 1'b1, 6'd8, 6'd8, 32'h0000_00C3, 32'h0000_005A, 16, 3);

        cur_test = "rst_after";
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_rd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] m;
            int ww, rw, tt, n, pick;
            m  = 2'($urandom);
            ww = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(33, 63))
                                             : $urandom_range(1, 32);
            rw = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(33, 63))
                                             : $urandom_range(1, 32);
            tt   = model_tot(m, ww, rw);
            pick = $urandom_range(0, 9);
            if (!model_valid(m, ww, rw)) n = $urandom_range(0, 6);
            else if (pick < 7) n = tt;
            else if (pick < 9) n = $urandom_range(0, tt - 1);
            else n = tt + $urandom_range(1, 3);
            cur_test = $sformatf("rand%0d", t);
            run_xfer(m, 1'($urandom), 1'($urandom), 6'(ww), 6'(rw), $urandom, $urandom, n, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
